// File: rtl/ex_hazard_scheduler.sv
// Execute-stage hazard scheduler: operand forwarding selects, load-use and
// multiply stalls, and branch flushes for the pipelined RISC-V core.
module ex_hazard_scheduler #(
  parameter int MUL_LAT = 3,
  parameter int REG_AW  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic              id_is_mul,
  input  logic              ex_branch_taken,
  output logic [1:0]        Forward_AE,
  output logic [1:0]        Forward_BE,
  output logic              Stall_F,
  output logic              Stall_D,
  output logic              Stall_E,
  output logic              Flush_D,
  output logic              Flush_E,
  output logic              mul_busy
);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LAT - 1);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              is_load;
  } ex_slot_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              is_load;
  } mem_slot_t;

  // WB only ever feeds forwarding, so its load flag is never consulted.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
  } wb_slot_t;

  ex_slot_t  ex_q,  ex_d;
  mem_slot_t mem_q, mem_d;
  wb_slot_t  wb_q,  wb_d;
  logic [3:0] mul_cnt_q, mul_cnt_d;

  logic mem_writer, wb_writer, busy, lu, br;

  always_comb begin
    mem_writer = mem_q.valid & mem_q.reg_write & (mem_q.rd != '0);
    wb_writer  = wb_q.valid & wb_q.reg_write & (wb_q.rd != '0);
    busy       = (mul_cnt_q != 4'd0);
    lu = ex_q.valid & ex_q.is_load & (ex_q.rd != '0) & id_valid &
         ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2)) & !busy;
    br = ex_q.valid & ex_branch_taken & !busy;
  end

  // MEM wins over WB because it carries the younger result.
  always_comb begin
    Forward_AE = FWD_RF;
    Forward_BE = FWD_RF;
    if (ex_q.valid) begin
      if (mem_writer && !mem_q.is_load && (mem_q.rd == ex_q.rs1))
        Forward_AE = FWD_MEM;
      else if (wb_writer && (wb_q.rd == ex_q.rs1))
        Forward_AE = FWD_WB;
      if (mem_writer && !mem_q.is_load && (mem_q.rd == ex_q.rs2))
        Forward_BE = FWD_MEM;
      else if (wb_writer && (wb_q.rd == ex_q.rs2))
        Forward_BE = FWD_WB;
    end
  end

  always_comb begin
    mul_busy = busy;
    Stall_E  = busy;
    Stall_F  = (lu & !br) | busy;
    Stall_D  = (lu & !br) | busy;
    Flush_D  = br;
    Flush_E  = br | lu;
  end

  always_comb begin
    ex_d      = ex_q;
    mem_d     = mem_q;
    wb_d      = '{valid: mem_q.valid, rd: mem_q.rd, reg_write: mem_q.reg_write};
    mul_cnt_d = mul_cnt_q;
    if (busy) begin
      mul_cnt_d = mul_cnt_q - 4'd1;
      mem_d     = '0;
    end else begin
      mem_d = '{valid: ex_q.valid, rd: ex_q.rd, reg_write: ex_q.reg_write,
                is_load: ex_q.is_load};
      if (Flush_E || !id_valid) begin
        ex_d = '0;
      end else begin
        ex_d = '{valid: 1'b1, rs1: id_rs1, rs2: id_rs2, rd: id_rd,
                 reg_write: id_reg_write, is_load: id_is_load};
        if (id_is_mul) mul_cnt_d = MUL_CNT_INIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      mul_cnt_q <= 4'd0;
    end else begin
      ex_q      <= ex_d;
      mem_q     <= mem_d;
      wb_q      <= wb_d;
      mul_cnt_q <= mul_cnt_d;
    end
  end

endmodule

// File: tb/tb_ex_hazard_scheduler.sv
// Directed bench for ex_hazard_scheduler with a queue of expected output
// vectors; one instance per multiply latency under test.
module tb_ex_hazard_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_reg_write, id_is_load, id_is_mul, ex_branch_taken;
  logic [4:0] id_rs1, id_rs2, id_rd;

  logic [1:0] fa3, fb3, fa1, fb1;
  logic sf3, sd3, se3, fd3, fe3, mb3;
  logic sf1, sd1, se1, fd1, fe1, mb1;

  int checks = 0;
  int errors = 0;

  logic [9:0] exp_q[$];
  string      tag_q[$];

  always #5 clk = ~clk;

  ex_hazard_scheduler #(.MUL_LAT(3), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_is_load(id_is_load), .id_is_mul(id_is_mul),
    .ex_branch_taken(ex_branch_taken), .Forward_AE(fa3), .Forward_BE(fb3),
    .Stall_F(sf3), .Stall_D(sd3), .Stall_E(se3), .Flush_D(fd3),
    .Flush_E(fe3), .mul_busy(mb3));

  ex_hazard_scheduler #(.MUL_LAT(1), .REG_AW(5)) dut1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_is_load(id_is_load), .id_is_mul(id_is_mul),
    .ex_branch_taken(ex_branch_taken), .Forward_AE(fa1), .Forward_BE(fb1),
    .Stall_F(sf1), .Stall_D(sd1), .Stall_E(se1), .Flush_D(fd1),
    .Flush_E(fe1), .mul_busy(mb1));

  wire [9:0] obs3 = {fa3, fb3, sf3, sd3, se3, fd3, fe3, mb3};
  wire [9:0] obs1 = {fa1, fb1, sf1, sd1, se1, fd1, fe1, mb1};

  // {FA, FB, Stall_F, Stall_D, Stall_E, Flush_D, Flush_E, mul_busy}
  function automatic logic [9:0] ev(input logic [1:0] fa, input logic [1:0] fb,
                                    input logic st, input logic fd,
                                    input logic fe, input logic mb);
    return {fa, fb, st, st, mb, fd, fe, mb};
  endfunction

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic rw, input logic ld,
                        input logic mul);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_reg_write = rw; id_is_load = ld; id_is_mul = mul;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    ex_branch_taken = 1'b0;
  endtask

  // Queue the expected vector for this cycle, sample mid-cycle, then advance.
  task automatic tick(input string tag, input logic [9:0] e, input bit use1);
    logic [9:0] want;
    logic [9:0] got;
    string      t;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    got  = use1 ? obs1 : obs3;
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", t, got, want);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    do_reset();
    ex_branch_taken = 1'b1;
    tick("reset_outputs", ev(2'b00, 2'b00, 0, 0, 0, 0), 0);

    // back-to-back ALU
    idle();
    set_id(1, 5'd1, 5'd2, 5'd5, 1, 0, 0);
    tick("alu_a", ev(2'b00, 2'b00, 0, 0, 0, 0), 0);
    set_id(1, 5'd5, 5'd5, 5'd6, 1, 0, 0);
    tick("alu_b", ev(2'b00, 2'b00, 0, 0, 0, 0), 0);
    set_id(1, 5'd5, 5'd0, 5'd7, 1, 0, 0);
    tick("alu_fwd_mem", ev(2'b10, 2'b10, 0, 0, 0, 0), 0);
    idle();
    tick("alu_fwd_wb", ev(2'b01, 2'b00, 0, 0, 0, 0), 0);

    // load-use
    do_reset();
    set_id(1, 5'd1, 5'd0, 5'd3, 1, 1, 0);
    tick("lu_load", ev(2'b00, 2'b00, 0, 0, 0, 0), 0);
    set_id(1, 5'd3, 5'd1, 5'd4, 1, 0, 0);
    tick("lu_stall", ev(2'b00, 2'b00, 1, 0, 1, 0), 0);
    tick("lu_bubble", ev(2'b00, 2'b00, 0, 0, 0, 0), 0);
    set_id(1, 5'd1, 5'd0, 5'd3, 1, 1, 0);
    tick("lu_consumer_wb", ev(2'b01, 2'b00, 0, 0, 0, 0), 0);
    set_id(1, 5'd1, 5'd2, 5'd4, 1, 0, 0);
    tick("lu_independent", ev(2'b00, 2'b00, 0, 0, 0, 0), 0);
    idle();
    tick("lu_after", ev(2'b00, 2'b00, 0, 0, 0, 0), 0);

    // x0 suppression
    do_reset();
    set_id(1, 5'd1, 5'd0, 5'd0, 1, 1, 0);
    tick("x0_lw", ev(2'b00, 2'b00, 0, 0, 0, 0), 0);
    set_id(1, 5'd0, 5'd0, 5'd4, 1, 0, 0);
    tick("x0_no_lu", ev(2'b00, 2'b00, 0, 0, 0, 0), 0);
    set_id(1, 5'd1, 5'd2, 5'd0, 1, 0, 0);
    tick("x0_no_fwd_wb", ev(2'b00, 2'b00, 0, 0, 0, 0), 0);
    set_id(1, 5'd0, 5'd0, 5'd1, 1, 0, 0);
    tick("x0_d", ev(2'b00, 2'b00, 0, 0, 0, 0), 0);
    idle();
    tick("x0_no_fwd_mem", ev(2'b00, 2'b00, 0, 0, 0, 0), 0);

    // multiply, MUL_LAT = 3; the mul reads x10 so MEM/WB bubbles are visible
    do_reset();
    set_id(1, 5'd1, 5'd2, 5'd10, 1, 0, 0);
    tick("mul3_prod", ev(2'b00, 2'b00, 0, 0, 0, 0), 0);
    set_id(1, 5'd10, 5'd11, 5'd8, 1, 0, 1);
    tick("mul3_pre", ev(2'b00, 2'b00, 0, 0, 0, 0), 0);
    set_id(1, 5'd8, 5'd8, 5'd9, 1, 0, 0);
    tick("mul3_stall1", ev(2'b10, 2'b00, 1, 0, 0, 1), 0);
    tick("mul3_stall2", ev(2'b01, 2'b00, 1, 0, 0, 1), 0);
    tick("mul3_last", ev(2'b00, 2'b00, 0, 0, 0, 0), 0);
    idle();
    tick("mul3_consumer", ev(2'b10, 2'b10, 0, 0, 0, 0), 0);

    // multiply, MUL_LAT = 1
    do_reset();
    set_id(1, 5'd1, 5'd2, 5'd10, 1, 0, 0);
    tick("mul1_prod", ev(2'b00, 2'b00, 0, 0, 0, 0), 1);
    set_id(1, 5'd10, 5'd11, 5'd8, 1, 0, 1);
    tick("mul1_pre", ev(2'b00, 2'b00, 0, 0, 0, 0), 1);
    set_id(1, 5'd8, 5'd8, 5'd9, 1, 0, 0);
    tick("mul1_no_stall", ev(2'b10, 2'b00, 0, 0, 0, 0), 1);
    idle();
    tick("mul1_consumer", ev(2'b10, 2'b10, 0, 0, 0, 0), 1);

    // branch beats load-use
    do_reset();
    set_id(1, 5'd1, 5'd0, 5'd3, 1, 1, 0);
    tick("br_load", ev(2'b00, 2'b00, 0, 0, 0, 0), 0);
    set_id(1, 5'd3, 5'd1, 5'd4, 1, 0, 0);
    ex_branch_taken = 1'b1;
    tick("br_vs_lu", ev(2'b00, 2'b00, 0, 1, 1, 0), 0);
    tick("br_ex_bubble", ev(2'b00, 2'b00, 0, 0, 0, 0), 0);

    // reset mid-multiply
    do_reset();
    set_id(1, 5'd1, 5'd2, 5'd8, 1, 0, 1);
    tick("rst_mul_issue", ev(2'b00, 2'b00, 0, 0, 0, 0), 0);
    set_id(1, 5'd8, 5'd8, 5'd9, 1, 0, 0);
    tick("rst_mul_cnt2", ev(2'b00, 2'b00, 1, 0, 0, 1), 0);
    rst_n = 1'b0;
    tick("rst_mul_cnt1", ev(2'b00, 2'b00, 1, 0, 0, 1), 0);
    rst_n = 1'b1;
    set_id(1, 5'd1, 5'd2, 5'd5, 1, 0, 0);
    ex_branch_taken = 1'b1;
    tick("rst_mul_cleared", ev(2'b00, 2'b00, 0, 0, 0, 0), 0);
    set_id(1, 5'd5, 5'd5, 5'd6, 1, 0, 0);
    ex_branch_taken = 1'b0;
    tick("rst_flow_a", ev(2'b00, 2'b00, 0, 0, 0, 0), 0);
    idle();
    tick("rst_flow_fwd", ev(2'b10, 2'b10, 0, 0, 0, 0), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
